// File: rtl/disp_pkg.sv
// disp_pkg: shared display types, conversion FSM states and the 7-segment digit decoder
package disp_pkg;
  localparam int BCD_W = 4;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  // Active-high segments, bit order gfedcba; non-decimal codes blank the digit
  function automatic logic [6:0] seg7(input bcd_digit_t d);
    case (d)
      4'd0: seg7 = 7'b0111111;
      4'd1: seg7 = 7'b0000110;
      4'd2: seg7 = 7'b1011011;
      4'd3: seg7 = 7'b1001111;
      4'd4: seg7 = 7'b1100110;
      4'd5: seg7 = 7'b1101101;
      4'd6: seg7 = 7'b1111101;
      4'd7: seg7 = 7'b0000111;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
  import disp_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to BCD converter with held result
module bin_to_bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      overflow
);
  localparam int SW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [63:0] LIM = 64'(10 ** DISP_DIGITS - 1);
  conv_state_t state, nxt;
  logic [WIDTH-1:0] sh;
  logic [SW-1:0] scr, cor, scr_nxt;
  logic [CW-1:0] cnt;
  logic ovf_c;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_add
    bcd_add3 u_add3 (.d(scr[BCD_W*i +: BCD_W]), .q(cor[BCD_W*i +: BCD_W]));
  end
  // Correct every digit first, then shift the next binary bit into the units digit
  assign scr_nxt = {cor[SW-2:0], sh[WIDTH-1]};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    nxt = (state == IDLE)  ? (start ? SHIFT : IDLE) :
          (state == SHIFT) ? ((cnt == CW'(1)) ? DONE : SHIFT) : IDLE;
  end
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_c    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      sh    <= bin;
      scr   <= '0;
      cnt   <= CW'(WIDTH);
      ovf_c <= 64'(bin) > LIM;
    end else if (state == SHIFT) begin
      sh  <= {sh[WIDTH-2:0], 1'b0};
      scr <= scr_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bcd      <= scr_nxt;
        overflow <= ovf_c;
      end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: vector table, corner sequences and random checks against a decimal model
module tb_bin_to_bcd_seq;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] bin = '0;
  logic busy, done, overflow;
  logic [19:0] bcd;
  int total = 0, bad = 0;

  bin_to_bcd_seq dut (.clk(clk), .reset(reset), .start(start), .bin(bin),
                      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct {logic [15:0] b; logic [19:0] e; logic o;} vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
    return r;
  endfunction

  // Start a conversion from IDLE; lat = negedges after the accepting edge until done is seen
  task automatic conv(input logic [15:0] b, output int lat);
    @(negedge clk);
    start = 1; bin = b;
    @(negedge clk);
    start = 0; bin = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, n;
    logic [15:0] r;
    vecs[0] = '{16'd0,     20'h00000, 1'b0};
    vecs[1] = '{16'd9999,  20'h09999, 1'b0};
    vecs[2] = '{16'd10000, 20'h10000, 1'b1};
    vecs[3] = '{16'd65535, 20'h65535, 1'b1};
    vecs[4] = '{16'd1234,  20'h01234, 1'b0};
    vecs[5] = '{16'd5,     20'h00005, 1'b0};
    vecs[6] = '{16'd59999, 20'h59999, 1'b1};
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_bcd", 32'(bcd), 0);
    chk("reset_ovf", 32'(overflow), 0);
    @(negedge clk) reset = 0;

    // bin=0: latency and busy width
    @(negedge clk);
    start = 1; bin = 0;
    @(negedge clk);
    start = 0;
    n = 0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (busy) n++;
      if (done && lat < 0) lat = c;
      @(negedge clk);
    end
    chk("zero_latency", 32'(lat), 16);
    chk("zero_busy_cycles", 32'(n), 17);
    chk("zero_bcd", 32'(bcd), 0);

    for (int v = 0; v < 7; v++) begin
      conv(vecs[v].b, lat);
      chk("vec_latency", 32'(lat), 16);
      chk("vec_bcd", 32'(bcd), 32'(vecs[v].e));
      chk("vec_ovf", 32'(overflow), 32'(vecs[v].o));
      @(negedge clk);
      chk("vec_done_pulse", 32'(done), 0);
    end

    // Result holds while idle and through a later conversion until its done
    repeat (5) @(negedge clk);
    chk("hold_idle", 32'(bcd), 32'h01234 == 32'(vecs[4].e) ? 32'(vecs[6].e) : 0);
    @(negedge clk);
    start = 1; bin = 16'd4321;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    chk("hold_during", 32'(bcd), 32'h59999);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("hold_then_new", 32'(bcd), 32'h04321);

    // start held high: conversions every 18 cycles
    @(negedge clk);
    start = 1; bin = 16'd42;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("cont_first_bcd", 32'(bcd), 32'h00042);
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("cont_spacing", 32'(n), 18);
    chk("cont_second_bcd", 32'(bcd), 32'h00042);
    start = 0;
    repeat (3) @(negedge clk);

    // start pulse mid-conversion is ignored
    @(negedge clk);
    start = 1; bin = 16'd100;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    start = 1; bin = 16'd999;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("ignore_latency", 32'(n), 10);
    chk("ignore_bcd", 32'(bcd), 32'h00100);
    n = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("ignore_no_restart", 32'(n), 0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start = 1; bin = 16'd4321;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_done", 32'(done), 0);
    chk("areset_bcd", 32'(bcd), 0);
    chk("areset_ovf", 32'(overflow), 0);
    @(negedge clk) reset = 0;
    conv(16'd777, lat);
    chk("after_reset_latency", 32'(lat), 16);
    chk("after_reset_bcd", 32'(bcd), 32'h00777);

    // Random values against the decimal model
    for (int t = 0; t < 1500; t++) begin
      r = 16'($urandom);
      if (t % 4 == 0) r = 16'($urandom_range(9990, 10010));
      conv(r, lat);
      chk("rand_latency", 32'(lat), 16);
      chk("rand_bcd", 32'(bcd), 32'(ref_bcd(int'(r))));
      chk("rand_ovf", 32'(overflow), 32'(int'(r) > 9999));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
